// File: rtl/mhp_pkg.sv
// Constants, error codes and FSM encodings shared by the MHP frame builder and RX parser.
package mhp_pkg;

    localparam int unsigned MHP_HDR_BYTES  = 7;
    localparam int unsigned MHP_SCS_BYTES  = 2;
    localparam logic [15:0] MHP_BCAST_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_CSUM  = 3'd1,
        ERR_SHORT = 3'd2,
        ERR_LONG  = 3'd3,
        ERR_SIZE  = 3'd4,
        ERR_ADDR  = 3'd5
    } mhp_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_END  = 2'd3
    } mhp_rx_state_e;

    typedef struct packed {
        logic [15:0] dst;
        logic [15:0] src;
        logic [15:0] size;
        logic [7:0]  d_type;
    } mhp_hdr_t;

endpackage

// File: rtl/mhp_rx_parser_if.sv
// RX FIFO pop handshake plus parsed header, payload stream and frame status.
interface mhp_rx_parser_if;

    logic [7:0]  i_rdata;
    logic        i_rready;
    logic        o_rreq;
    logic        o_hdr_valid;
    logic [15:0] o_dst;
    logic [15:0] o_src;
    logic [15:0] o_size;
    logic        o_dir;
    logic [6:0]  o_type;
    logic [7:0]  o_pdata;
    logic        o_pvalid;
    logic        o_plast;
    logic        o_frame_done;
    logic        o_frame_ok;
    logic [2:0]  o_err;
    logic [7:0]  o_err_cnt;

    modport master (
        input  i_rdata, i_rready,
        output o_rreq, o_hdr_valid, o_dst, o_src, o_size, o_dir, o_type,
               o_pdata, o_pvalid, o_plast, o_frame_done, o_frame_ok, o_err, o_err_cnt
    );

    modport slave (
        output i_rdata, i_rready,
        input  o_rreq, o_hdr_valid, o_dst, o_src, o_size, o_dir, o_type,
               o_pdata, o_pvalid, o_plast, o_frame_done, o_frame_ok, o_err, o_err_cnt
    );

endinterface

// File: rtl/mhp_scs_acc.sv
// 16-bit modular byte-sum accumulator used for the MHP SCS checksum.
module mhp_scs_acc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_add,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_sum
);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            o_sum <= 16'h0000;
        end else if (i_add) begin
            o_sum <= o_sum + 16'(i_byte);
        end
    end

endmodule

// File: rtl/mhp_rx_parser.sv
// MHP receive parser: pops the RX FIFO, decodes the header, streams the payload
// and checks the trailing SCS, reporting per-frame status and an error count.
module mhp_rx_parser
    import mhp_pkg::*;
#(
    parameter logic [15:0] MY_ADDR     = 16'h0001,
    parameter int unsigned MAX_PAYLOAD = 512,
    parameter int unsigned GAP_TIMEOUT = 62
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mhp_rx_parser_if.master   bus
);

    localparam int unsigned IW = 11;
    localparam int unsigned GW = 6;
    localparam int unsigned XW = 17;
    localparam logic [IW-1:0] IDX_MAX  = '1;
    localparam logic [GW-1:0] GAP_LIM  = GW'(GAP_TIMEOUT);
    localparam logic [15:0]   MAX_SIZE = 16'(MAX_PAYLOAD);

    mhp_rx_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    mhp_hdr_t      hdr_q, hdr_d, out_hdr_q, out_hdr_d;
    mhp_err_e      hdr_err_q, hdr_err_d, err_q, err_d, end_err;
    logic [15:0]   scs_q, scs_d, acc_sum;
    logic [7:0]    pdata_q, pdata_d, err_cnt_q, err_cnt_d;
    logic          hdr_valid_q, hdr_valid_d, pvalid_q, pvalid_d, plast_q, plast_d;
    logic          done_q, done_d, ok_q, ok_d;
    logic          rreq_c, rx_rdy_c, acc_clr_c, acc_add_c;
    logic [XW-1:0] idx_x, pay_end, scs_end;

    assign idx_x    = XW'(idx_q);
    assign pay_end  = XW'(MHP_HDR_BYTES) + XW'(hdr_q.size);
    assign scs_end  = pay_end + XW'(MHP_SCS_BYTES);
    assign rx_rdy_c = bus.i_rready & ~i_rst;

    mhp_scs_acc u_acc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (acc_clr_c),
        .i_add  (acc_add_c),
        .i_byte (bus.i_rdata),
        .o_sum  (acc_sum)
    );

    // Next-state, byte classification and end-of-frame verdict
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        hdr_d       = hdr_q;
        hdr_err_d   = hdr_err_q;
        scs_d       = scs_q;
        out_hdr_d   = out_hdr_q;
        pdata_d     = pdata_q;
        err_d       = err_q;
        ok_d        = ok_q;
        err_cnt_d   = err_cnt_q;
        hdr_valid_d = 1'b0;
        pvalid_d    = 1'b0;
        plast_d     = 1'b0;
        done_d      = 1'b0;
        rreq_c      = 1'b0;
        acc_clr_c   = 1'b0;
        acc_add_c   = 1'b0;
        end_err     = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                idx_d     = '0;
                gap_d     = '0;
                hdr_err_d = ERR_NONE;
                acc_clr_c = 1'b1;
                if (rx_rdy_c) begin
                    rreq_c  = 1'b1;
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                state_d   = ST_WAIT;
                idx_d     = (idx_q == IDX_MAX) ? idx_q : idx_q + IW'(1);
                acc_add_c = (idx_x < pay_end);
                if (idx_x < XW'(MHP_HDR_BYTES)) begin
                    case (idx_q[2:0])
                        3'd0: hdr_d.dst[7:0]   = bus.i_rdata;
                        3'd1: hdr_d.dst[15:8]  = bus.i_rdata;
                        3'd2: hdr_d.src[7:0]   = bus.i_rdata;
                        3'd3: hdr_d.src[15:8]  = bus.i_rdata;
                        3'd4: hdr_d.size[7:0]  = bus.i_rdata;
                        3'd5: hdr_d.size[15:8] = bus.i_rdata;
                        3'd6: hdr_d.d_type     = bus.i_rdata;
                        default: ;
                    endcase
                    // Header is complete on d_type: screen size, then address
                    if (idx_q[2:0] == 3'd6) begin
                        if (hdr_q.size > MAX_SIZE) begin
                            hdr_err_d = ERR_SIZE;
                        end else if (hdr_q.dst != MY_ADDR && hdr_q.dst != MHP_BCAST_ADDR) begin
                            hdr_err_d = ERR_ADDR;
                        end else begin
                            hdr_valid_d = 1'b1;
                            out_hdr_d   = hdr_d;
                        end
                    end
                end else if (idx_x < pay_end) begin
                    if (hdr_err_q == ERR_NONE) begin
                        pvalid_d = 1'b1;
                        pdata_d  = bus.i_rdata;
                        plast_d  = (idx_x == pay_end - XW'(1));
                    end
                end else if (idx_x == pay_end) begin
                    scs_d[7:0] = bus.i_rdata;
                end else if (idx_x == pay_end + XW'(1)) begin
                    scs_d[15:8] = bus.i_rdata;
                end
            end
            ST_WAIT: begin
                if (rx_rdy_c) begin
                    rreq_c  = 1'b1;
                    gap_d   = '0;
                    state_d = ST_CAP;
                end else if (gap_q + GW'(1) == GAP_LIM) begin
                    if (hdr_err_q != ERR_NONE)   end_err = hdr_err_q;
                    else if (idx_x < scs_end)    end_err = ERR_SHORT;
                    else if (idx_x > scs_end)    end_err = ERR_LONG;
                    else if (scs_q != acc_sum)   end_err = ERR_CSUM;
                    else                         end_err = ERR_NONE;
                    state_d = ST_END;
                    done_d  = 1'b1;
                    err_d   = end_err;
                    ok_d    = (end_err == ERR_NONE);
                    if (end_err != ERR_NONE && end_err != ERR_ADDR && err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            hdr_q       <= '0;
            hdr_err_q   <= ERR_NONE;
            scs_q       <= '0;
            out_hdr_q   <= '0;
            pdata_q     <= '0;
            err_q       <= ERR_NONE;
            ok_q        <= 1'b0;
            err_cnt_q   <= '0;
            hdr_valid_q <= 1'b0;
            pvalid_q    <= 1'b0;
            plast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            hdr_q       <= hdr_d;
            hdr_err_q   <= hdr_err_d;
            scs_q       <= scs_d;
            out_hdr_q   <= out_hdr_d;
            pdata_q     <= pdata_d;
            err_q       <= err_d;
            ok_q        <= ok_d;
            err_cnt_q   <= err_cnt_d;
            hdr_valid_q <= hdr_valid_d;
            pvalid_q    <= pvalid_d;
            plast_q     <= plast_d;
            done_q      <= done_d;
        end
    end

    // The pop request must precede the capture cycle, so it is decoded from state
    assign bus.o_rreq       = rreq_c;
    assign bus.o_hdr_valid  = hdr_valid_q;
    assign bus.o_dst        = out_hdr_q.dst;
    assign bus.o_src        = out_hdr_q.src;
    assign bus.o_size       = out_hdr_q.size;
    assign bus.o_dir        = out_hdr_q.d_type[7];
    assign bus.o_type       = out_hdr_q.d_type[6:0];
    assign bus.o_pdata      = pdata_q;
    assign bus.o_pvalid     = pvalid_q;
    assign bus.o_plast      = plast_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_frame_ok   = ok_q;
    assign bus.o_err        = err_q;
    assign bus.o_err_cnt    = err_cnt_q;

endmodule
